tfs_huffman_stream_encoder: RTL and testbench

- Streaming, parametrised TFS Huffman encoder. Trits are accepted one per cycle over a valid/ready handshake.
- Encoded bits are packed LSB-first into OUT_W-bit words with backpressure. Blocks of BLOCK_TRITS trits are framed with out_last and a per-block bit count and guardian trit.
- Sits between the TFS block cache and the STT-MRAM write path. Replaces the single-cycle 32-trit encoder for arbitrary block sizes and bus widths.

---
 rtl/tfs_huffman_stream_encoder.sv | 232 +++++++++++++++++++++++
 tb/tb_tfs_huffman_stream_encoder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tfs_huffman_stream_encoder.sv
// rtl/tfs_huffman_stream_encoder.sv - streaming TFS Huffman encoder, LSB-first word packing with block framing
// Optional feature macro: TFS_GUARDIAN_APPEND_EN (appends the block guardian as a trailing symbol before flush)
module tfs_huffman_stream_encoder #(
    parameter int BLOCK_TRITS = 32,
    parameter int OUT_W       = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [1:0]                         in_trit,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [OUT_W-1:0]                   out_data,
    output logic                               out_last,
    output logic [$clog2(OUT_W+1)-1:0]         out_bits,
    output logic                               blk_done,
    output logic [$clog2(2*BLOCK_TRITS+3)-1:0] blk_bits,
    output logic [1:0]                         blk_guardian,
    output logic                               err
);
    localparam int AW  = 2 * OUT_W;
    localparam int FW  = $clog2(AW + 1);
    localparam int OBW = $clog2(OUT_W + 1);
    localparam int BBW = $clog2(2 * BLOCK_TRITS + 3);
    localparam int CW  = (BLOCK_TRITS > 1) ? $clog2(BLOCK_TRITS) : 1;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_GUARD  = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       guard_q, guard_d;
    logic [BBW-1:0]   bits_q, bits_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [OBW-1:0]   out_bits_q, out_bits_d;
    logic             blk_done_q, blk_done_d;
    logic [BBW-1:0]   blk_bits_q, blk_bits_d;
    logic [1:0]       blk_guardian_q, blk_guardian_d;
    logic             err_q, err_d;

    logic [1:0]       trit_code, trit_len, trit_val;
    logic             trit_bad;
    logic             accept, out_free, emit, last_word;
    logic [FW-1:0]    fill_sh;
    logic [AW-1:0]    acc_sh;
    logic [1:0]       app_code, app_len;

    // Guardian values stay in 0..2, so a 3-bit sum and one conditional subtract suffice.
    function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    assign in_ready = (state_q == ST_ACCEPT) && (fill_q <= FW'(AW - 2));

    // Trit to LSB-first code: 0 -> '0', +1 -> '1','0', -1 -> '1','1'; illegal encodes as 0.
    always_comb begin
        trit_code = 2'b00;
        trit_len  = 2'd1;
        trit_val  = 2'd0;
        trit_bad  = 1'b0;
        case (in_trit)
            2'b01: begin
                trit_code = 2'b01;
                trit_len  = 2'd2;
                trit_val  = 2'd1;
            end
            2'b10: begin
                trit_code = 2'b11;
                trit_len  = 2'd2;
                trit_val  = 2'd2;
            end
            2'b11:   trit_bad = 1'b1;
            default: ;
        endcase
    end

`ifdef TFS_GUARDIAN_APPEND_EN
    logic [1:0] gsym_code, gsym_len;

    // Guardian trailer symbol uses the same code shape as a trit of that value.
    always_comb begin
        gsym_code = 2'b00;
        gsym_len  = 2'd1;
        if (guard_q == 2'd1) begin
            gsym_code = 2'b01;
            gsym_len  = 2'd2;
        end else if (guard_q == 2'd2) begin
            gsym_code = 2'b11;
            gsym_len  = 2'd2;
        end
    end
`endif

    // Next state: word emit shifts the accumulator first, then the new symbol lands above the remaining fill.
    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        fill_d         = fill_q;
        cnt_d          = cnt_q;
        guard_d        = guard_q;
        bits_d         = bits_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_last_d     = out_last_q;
        out_bits_d     = out_bits_q;
        blk_done_d     = 1'b0;
        blk_bits_d     = blk_bits_q;
        blk_guardian_d = blk_guardian_q;
        err_d          = err_q;
        app_code       = 2'b00;
        app_len        = 2'd0;
        fill_sh        = fill_q;
        acc_sh         = acc_q;

        accept    = in_valid && in_ready;
        out_free  = !out_valid_q || out_ready;
        last_word = (state_q == ST_FLUSH) && (fill_q <= FW'(OUT_W));
        emit      = out_free && ((state_q == ST_FLUSH) ? (fill_q != '0) : (fill_q >= FW'(OUT_W)));

        if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_q[OUT_W-1:0];
            out_last_d  = last_word;
            out_bits_d  = last_word ? fill_q[OBW-1:0] : OBW'(OUT_W);
            acc_sh      = acc_q >> OUT_W;
            fill_sh     = last_word ? '0 : (fill_q - FW'(OUT_W));
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            app_code = trit_code;
            app_len  = trit_len;
            guard_d  = mod3_add(guard_q, trit_val);
            err_d    = err_q | trit_bad;
            if (cnt_q == CW'(BLOCK_TRITS - 1)) begin
                cnt_d = '0;
`ifdef TFS_GUARDIAN_APPEND_EN
                state_d = ST_GUARD;
`else
                state_d = ST_FLUSH;
`endif
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

`ifdef TFS_GUARDIAN_APPEND_EN
        // The trailer waits only if a stalled output leaves no room for two more bits.
        if ((state_q == ST_GUARD) && (fill_sh <= FW'(AW - 2))) begin
            app_code = gsym_code;
            app_len  = gsym_len;
            state_d  = ST_FLUSH;
        end
`endif

        acc_d  = acc_sh | ({{(AW-2){1'b0}}, app_code} << fill_sh);
        fill_d = fill_sh + FW'(app_len);
        bits_d = bits_q + BBW'(app_len);

        // Block closes when its final word is taken downstream.
        if ((state_q == ST_FLUSH) && out_valid_q && out_ready && out_last_q) begin
            state_d        = ST_ACCEPT;
            blk_done_d     = 1'b1;
            blk_bits_d     = bits_q;
            blk_guardian_d = guard_q;
            guard_d        = '0;
            bits_d         = '0;
            acc_d          = '0;
            fill_d         = '0;
            cnt_d          = '0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_ACCEPT;
            acc_q          <= '0;
            fill_q         <= '0;
            cnt_q          <= '0;
            guard_q        <= '0;
            bits_q         <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_last_q     <= 1'b0;
            out_bits_q     <= '0;
            blk_done_q     <= 1'b0;
            blk_bits_q     <= '0;
            blk_guardian_q <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            fill_q         <= fill_d;
            cnt_q          <= cnt_d;
            guard_q        <= guard_d;
            bits_q         <= bits_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_last_q     <= out_last_d;
            out_bits_q     <= out_bits_d;
            blk_done_q     <= blk_done_d;
            blk_bits_q     <= blk_bits_d;
            blk_guardian_q <= blk_guardian_d;
            err_q          <= err_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_last     = out_last_q;
    assign out_bits     = out_bits_q;
    assign blk_done     = blk_done_q;
    assign blk_bits     = blk_bits_q;
    assign blk_guardian = blk_guardian_q;
    assign err          = err_q;

endmodule

// File: tb/tb_tfs_huffman_stream_encoder.sv
// tb/tb_tfs_huffman_stream_encoder.sv - directed table-driven bench for tfs_huffman_stream_encoder
module tb_tfs_huffman_stream_encoder;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic [4:0]  bits;
    } word_t;

    typedef struct {
        bit               dut;
        int               pat;
        int               nw;
        logic [4:0][15:0] w;
        int               lbits;
        int               bbits;
        logic [1:0]       g;
        logic             e;
    } vec_t;

`ifdef TFS_GUARDIAN_APPEND_EN
    localparam int ZW = 3;
    localparam int ZB = 33;
    localparam int MW = 5;
    localparam int MB = 66;
`else
    localparam int ZW = 2;
    localparam int ZB = 32;
    localparam int MW = 4;
    localparam int MB = 64;
`endif

    logic clk, rst;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_blk_done, a_err;
    logic [1:0]  a_in_trit, a_blk_guardian;
    logic [15:0] a_out_data;
    logic [4:0]  a_out_bits;
    logic [6:0]  a_blk_bits;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_blk_done, b_err;
    logic [1:0]  b_in_trit, b_blk_guardian;
    logic [3:0]  b_out_data;
    logic [2:0]  b_out_bits;
    logic [3:0]  b_blk_bits;

    word_t       qa[$];
    word_t       qb[$];
    int          a_done_n, b_done_n;
    logic [6:0]  a_done_bits;
    logic [3:0]  b_done_bits;
    logic [1:0]  a_done_g, b_done_g;

    int          n_checks = 0;
    int          n_errors = 0;
    vec_t        vt[5];

    tfs_huffman_stream_encoder #(.BLOCK_TRITS(32), .OUT_W(16)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_trit(a_in_trit),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_last(a_out_last), .out_bits(a_out_bits),
        .blk_done(a_blk_done), .blk_bits(a_blk_bits), .blk_guardian(a_blk_guardian), .err(a_err)
    );

    tfs_huffman_stream_encoder #(.BLOCK_TRITS(5), .OUT_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_trit(b_in_trit),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .out_bits(b_out_bits),
        .blk_done(b_blk_done), .blk_bits(b_blk_bits), .blk_guardian(b_blk_guardian), .err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output collector: a word valid with ready at the falling edge handshakes at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            a_done_n = 0;
            b_done_n = 0;
        end else begin
            if (a_out_valid && a_out_ready)
                qa.push_back('{data: a_out_data, last: a_out_last, bits: a_out_bits});
            if (b_out_valid && b_out_ready)
                qb.push_back('{data: {12'h000, b_out_data}, last: b_out_last, bits: {2'b00, b_out_bits}});
            if (a_blk_done) begin
                a_done_n++;
                a_done_bits = a_blk_bits;
                a_done_g    = a_blk_guardian;
            end
            if (b_blk_done) begin
                b_done_n++;
                b_done_bits = b_blk_bits;
                b_done_g    = b_blk_guardian;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input bit dut, input int pat, input int nw,
                        input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                        input logic [15:0] w3, input logic [15:0] w4,
                        input int lbits, input int bbits, input logic [1:0] g, input logic e);
        vt[i].dut = dut;   vt[i].pat = pat;     vt[i].nw = nw;
        vt[i].w[0] = w0;   vt[i].w[1] = w1;     vt[i].w[2] = w2;
        vt[i].w[3] = w3;   vt[i].w[4] = w4;
        vt[i].lbits = lbits; vt[i].bbits = bbits; vt[i].g = g; vt[i].e = e;
    endtask

    function automatic logic [1:0] trit_of(input int pat, input int k);
        case (pat)
            1:       return 2'b01;
            2:       return 2'b10;
            3:       return (k % 3 == 0) ? 2'b00 : ((k % 3 == 1) ? 2'b01 : 2'b10);
            4:       return (k == 3) ? 2'b11 : 2'b00;
            default: return 2'b00;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic push(input bit sel, input logic [1:0] t);
        int n;
        n = 0;
        if (sel) begin
            b_in_valid = 1'b1; b_in_trit = t;
        end else begin
            a_in_valid = 1'b1; a_in_trit = t;
        end
        @(negedge clk);
        while (!(sel ? b_in_ready : a_in_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            n_checks++;
            n_errors++;
            $display("FAIL push_timeout: in_ready stuck low, dut %0d", sel);
        end
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input string name);
        int n;
        n = 0;
        while ((sel ? b_done_n : a_done_n) == 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s done_timeout: no blk_done within %0d cycles", name, n);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic run_vector(input int i);
        vec_t  v;
        word_t w;
        int    got;
        v = vt[i];
        do_reset();
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        for (int k = 0; k < (v.dut ? 5 : 32); k++) push(v.dut, trit_of(v.pat, k));
        wait_done(v.dut, $sformatf("v%0d", i));
        got = v.dut ? qb.size() : qa.size();
        chk($sformatf("v%0d word_count", i), got, v.nw);
        for (int k = 0; k < v.nw && k < got; k++) begin
            w = v.dut ? qb[k] : qa[k];
            chk($sformatf("v%0d w%0d data", i, k), w.data, v.w[k]);
            chk($sformatf("v%0d w%0d last", i, k), w.last, (k == v.nw - 1));
            if (k == v.nw - 1) chk($sformatf("v%0d out_bits", i), w.bits, v.lbits);
        end
        chk($sformatf("v%0d done_count", i), v.dut ? b_done_n : a_done_n, 1);
        chk($sformatf("v%0d blk_bits", i), v.dut ? b_done_bits : a_done_bits, v.bbits);
        chk($sformatf("v%0d blk_guardian", i), v.dut ? b_done_g : a_done_g, v.g);
        chk($sformatf("v%0d err", i), v.dut ? b_err : a_err, v.e);
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_trit = 2'b00; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_trit = 2'b00; b_out_ready = 1'b0;

`ifdef TFS_GUARDIAN_APPEND_EN
        setv(0, 0, 0, 3, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 33, 2'd0, 1'b0);
        setv(1, 0, 1, 5, 16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h0003, 2, 66, 2'd2, 1'b0);
        setv(2, 0, 2, 5, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0001, 2, 66, 2'd1, 1'b0);
        setv(3, 1, 3, 3, 16'h000A, 16'h0005, 16'h0001, 16'h0000, 16'h0000, 2, 10, 2'd1, 1'b0);
        setv(4, 0, 4, 3, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 33, 2'd0, 1'b1);
`else
        setv(0, 0, 0, 2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16, 32, 2'd0, 1'b0);
        setv(1, 0, 1, 4, 16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h0000, 16, 64, 2'd2, 1'b0);
        setv(2, 0, 2, 4, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16, 64, 2'd1, 1'b0);
        setv(3, 1, 3, 2, 16'h000A, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 4, 8, 2'd1, 1'b0);
        setv(4, 0, 4, 2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16, 32, 2'd0, 1'b1);
`endif

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst out_valid", a_out_valid, 1'b0);
        chk("rst out_data", a_out_data, 16'h0000);
        chk("rst out_last", a_out_last, 1'b0);
        chk("rst out_bits", a_out_bits, 5'd0);
        chk("rst blk_done", a_blk_done, 1'b0);
        chk("rst blk_bits", a_blk_bits, 7'd0);
        chk("rst blk_guardian", a_blk_guardian, 2'd0);
        chk("rst err", a_err, 1'b0);
        chk("rst in_ready", a_in_ready, 1'b1);
        chk("rst b_out_valid", b_out_valid, 1'b0);

        for (int i = 0; i < 5; i++) run_vector(i);

        // Reset mid-block: err is still set from the illegal-trit vector
        a_out_ready = 1'b1;
        for (int k = 0; k < 10; k++) push(1'b0, 2'b00);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst out_valid", a_out_valid, 1'b0);
        chk("midrst in_ready", a_in_ready, 1'b1);
        chk("midrst err", a_err, 1'b0);
        for (int k = 0; k < 32; k++) push(1'b0, 2'b00);
        wait_done(1'b0, "midrst");
        chk("midrst done_count", a_done_n, 1);
        chk("midrst blk_bits", a_done_bits, ZB);
        chk("midrst word_count", qa.size(), ZW);

        // Backpressure: 32 x -1 with out_ready held low, then released
        do_reset();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_trit   = 2'b10;
        cnt = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (a_in_ready) cnt++;
        end
        chk("bp accepted_before_stall", cnt, 24);
        chk("bp in_ready", a_in_ready, 1'b0);
        chk("bp out_valid", a_out_valid, 1'b1);
        chk("bp out_data", a_out_data, 16'hFFFF);
        @(posedge clk);
        #1 a_out_ready = 1'b1;
        for (int j = 0; j < 300 && cnt < 32; j++) begin
            @(negedge clk);
            if (j < 2) begin
                chk($sformatf("bp nobubble%0d valid", j), a_out_valid, 1'b1);
                chk($sformatf("bp nobubble%0d data", j), a_out_data, 16'hFFFF);
            end
            if (a_in_ready) cnt++;
            @(posedge clk);
            #1;
            if (cnt >= 32) a_in_valid = 1'b0;
        end
        a_in_valid = 1'b0;
        chk("bp accepted_total", cnt, 32);
        wait_done(1'b0, "bp");
        chk("bp word_count", qa.size(), MW);
        for (int k = 0; k < 4 && k < qa.size(); k++)
            chk($sformatf("bp w%0d data", k), qa[k].data, 16'hFFFF);
        chk("bp blk_bits", a_done_bits, MB);
        chk("bp blk_guardian", a_done_g, 2'd1);
        chk("bp done_count", a_done_n, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
